// File: rtl/uart_pkg.sv
// Purpose: shared UART definitions for the receiver, transmitter and baud generator.
// Latency: none, because the package holds only types and constants.
// Backpressure: not applicable.
//   UART_DATA_BITS  : default data bits per frame
//   UART_OVERSAMPLE : default sample_tick pulses per bit period
//   uart_state_t    : frame-level receive/transmit state
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_sync.sv
// Purpose: two-flop synchronizer for one asynchronous input bit.
// Latency: 2 clk_in cycles from d to q.
// Backpressure: none; q follows d continuously.
//   clk_in : sampling clock
//   reset  : asynchronous, active-high; both flops load RESET_VAL
//   d      : asynchronous input
//   q      : synchronized output
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_in,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Purpose: oversampled 8N1-style UART receiver with a one-entry output register.
// Latency: rx_valid rises one clk_in after the stop-bit sample, which is mid stop bit.
// Backpressure: none; an unacknowledged byte is overwritten and sticky overrun is set.
//   clk_in, reset    : clock and asynchronous active-high reset
//   sample_tick      : OVERSAMPLE x baud enable; FSM and counters advance only on it
//   rx               : asynchronous serial line, idles high
//   rx_data/rx_valid : last good byte and its unconsumed flag; rx_ack clears rx_valid
//   framing_err      : one-cycle pulse when the stop bit samples low
//   overrun          : sticky, set when a good byte lands on an unconsumed one
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 framing_err,
  output logic                 overrun
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  // The start bit is re-checked half a bit after detection; the data and
  // stop bits are then sampled a full bit period apart, landing mid-bit.
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic rx_s;

  uart_sync #(
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk_in (clk_in),
    .reset  (reset),
    .d      (rx),
    .q      (rx_s)
  );

  uart_state_t          state, state_nxt;
  logic [TICK_W-1:0]    tick_cnt, tick_nxt;
  logic [BIT_W-1:0]     bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0] shift_reg, shift_nxt;
  logic                 frame_good;
  logic                 frame_bad;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_nxt;
      tick_cnt  <= tick_nxt;
      bit_cnt   <= bit_nxt;
      shift_reg <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    tick_nxt   = tick_cnt;
    bit_nxt    = bit_cnt;
    shift_nxt  = shift_reg;
    frame_good = 1'b0;
    frame_bad  = 1'b0;

    if (sample_tick) begin
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state_nxt = START;
            tick_nxt  = '0;
          end
        end

        START: begin
          if (tick_cnt == TICK_MID) begin
            tick_nxt  = '0;
            bit_nxt   = '0;
            // A line that is high again by mid start bit was a glitch.
            state_nxt = rx_s ? IDLE : DATA;
          end else begin
            tick_nxt = tick_cnt + TICK_W'(1);
          end
        end

        DATA: begin
          if (tick_cnt == TICK_LAST) begin
            tick_nxt  = '0;
            // Shift right so the first bit on the line ends up in the LSB.
            shift_nxt = {rx_s, shift_reg[DATA_BITS-1:1]};
            if (bit_cnt == BIT_LAST) begin
              bit_nxt   = '0;
              state_nxt = STOP;
            end else begin
              bit_nxt = bit_cnt + BIT_W'(1);
            end
          end else begin
            tick_nxt = tick_cnt + TICK_W'(1);
          end
        end

        STOP: begin
          if (tick_cnt == TICK_LAST) begin
            tick_nxt   = '0;
            state_nxt  = IDLE;
            frame_good = rx_s;
            frame_bad  = !rx_s;
          end else begin
            tick_nxt = tick_cnt + TICK_W'(1);
          end
        end

        default: state_nxt = IDLE;
      endcase
    end
  end

  // A completing frame takes priority over rx_ack, so a byte that lands in
  // the same cycle as an acknowledge stays valid and does not count as lost.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      framing_err <= frame_bad;
      if (frame_good) begin
        rx_data  <= shift_reg;
        rx_valid <= 1'b1;
        if (rx_valid && !rx_ack) begin
          overrun <= 1'b1;
        end
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Purpose: self-checking bench for uart_rx: directed table, corner sequences, random frames.
// Latency: checks are taken after each frame's stop bit has fully elapsed on the line.
// Backpressure: the bench drives rx_ack explicitly to exercise overrun and same-cycle cases.
module tb_uart_rx;

  localparam int DB = 8;
  localparam int OS = 16;

  logic          clk_in = 1'b0;
  logic          reset;
  logic          sample_tick = 1'b0;
  logic          rx;
  logic          rx_ack;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          framing_err;
  logic          overrun;

  uart_rx #(
    .DATA_BITS  (DB),
    .OVERSAMPLE (OS)
  ) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .sample_tick (sample_tick),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ack      (rx_ack),
    .framing_err (framing_err),
    .overrun     (overrun)
  );

  always #5 clk_in = ~clk_in;

  // Tick generator: one tick every tick_div clocks, changed on the falling edge.
  int tick_div = 1;
  int tick_ctr = 0;
  always @(negedge clk_in) begin
    tick_ctr++;
    sample_tick = ((tick_ctr % tick_div) == 0);
  end

  // Framing-error monitor: counts pulses and flags any pulse wider than one cycle.
  int fe_count = 0;
  int fe_wide  = 0;
  bit fe_prev  = 1'b0;
  always @(negedge clk_in) begin
    if (framing_err === 1'b1) fe_count++;
    if ((framing_err === 1'b1) && fe_prev) fe_wide++;
    fe_prev = (framing_err === 1'b1);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int c = 0;
    while (c < n) begin
      @(posedge clk_in);
      if (sample_tick) c++;
    end
  endtask

  // Drives one frame: start bit, DB data bits LSB first, one stop bit of the given level.
  task automatic send_frame(input logic [DB-1:0] d, input logic stop);
    @(posedge clk_in);
    #1 rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < DB; i++) begin
      #1 rx = d[i];
      wait_ticks(OS);
    end
    #1 rx = stop;
    wait_ticks(OS);
    #1 rx = 1'b1;
  endtask

  task automatic pulse_ack;
    @(posedge clk_in);
    #1 rx_ack = 1'b1;
    @(posedge clk_in);
    #1 rx_ack = 1'b0;
  endtask

  task automatic do_reset;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk_in);
    #1 reset = 1'b0;
  endtask

  task automatic check_out(input string nm, input logic [DB-1:0] e_data,
                           input logic e_valid, input logic e_ovr);
    #2;
    chk({nm, ".rx_data"},  32'(rx_data),  32'(e_data));
    chk({nm, ".rx_valid"}, 32'(rx_valid), 32'(e_valid));
    chk({nm, ".overrun"},  32'(overrun),  32'(e_ovr));
  endtask

  typedef struct {
    logic [DB-1:0] data;
    logic          stop;
    logic          ack;
    logic [DB-1:0] exp_data;
    logic          exp_valid;
    logic          exp_fe;
    logic          exp_ovr;
  } vec_t;

  vec_t tbl[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int            fe0;
    logic [DB-1:0] m_data;
    logic          m_valid;
    logic          m_ovr;

    // Starting state is data 0x3C, valid 0, overrun 0 (after the false-start section).
    tbl[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{8'h55, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{8'h22, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1};

    reset  = 1'b1;
    rx     = 1'b1;
    rx_ack = 1'b0;
    repeat (3) @(posedge clk_in);
    #2;
    chk("reset.rx_data",     32'(rx_data),     32'h0);
    chk("reset.rx_valid",    32'(rx_valid),    32'h0);
    chk("reset.framing_err", 32'(framing_err), 32'h0);
    chk("reset.overrun",     32'(overrun),     32'h0);
    reset = 1'b0;

    // False start: 5 ticks low, then back high.
    fe0 = fe_count;
    @(posedge clk_in);
    #1 rx = 1'b0;
    wait_ticks(5);
    #1 rx = 1'b1;
    wait_ticks(30);
    check_out("false_start", 8'h00, 1'b0, 1'b0);
    chk("false_start.fe", 32'(fe_count - fe0), 32'h0);
    send_frame(8'h3C, 1'b1);
    check_out("after_false_start", 8'h3C, 1'b1, 1'b0);
    pulse_ack;
    #1 chk("after_false_start.ack_valid", 32'(rx_valid), 32'h0);

    // Directed table: good frame, bad stop bit, overrun pair.
    for (int v = 0; v < 4; v++) begin
      fe0 = fe_count;
      send_frame(tbl[v].data, tbl[v].stop);
      wait_ticks(20);
      check_out($sformatf("tbl%0d", v), tbl[v].exp_data, tbl[v].exp_valid, tbl[v].exp_ovr);
      chk($sformatf("tbl%0d.fe", v), 32'(fe_count - fe0), 32'(tbl[v].exp_fe));
      if (tbl[v].ack) begin
        pulse_ack;
        #1;
        chk($sformatf("tbl%0d.ack_valid", v), 32'(rx_valid), 32'h0);
        chk($sformatf("tbl%0d.ack_ovr", v),   32'(overrun),  32'(tbl[v].exp_ovr));
      end
    end

    // Asynchronous reset during data bit 4 of 0xFF (overrun is set going in).
    fe0 = fe_count;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        @(posedge clk_in);
        wait_ticks(OS + 4 * OS + OS / 2);
        #1 reset = 1'b1;
        #3;
        chk("midreset.rx_data",     32'(rx_data),     32'h0);
        chk("midreset.rx_valid",    32'(rx_valid),    32'h0);
        chk("midreset.framing_err", 32'(framing_err), 32'h0);
        chk("midreset.overrun",     32'(overrun),     32'h0);
        @(posedge clk_in);
        #1 reset = 1'b0;
      end
    join
    wait_ticks(20);
    check_out("midreset_after", 8'h00, 1'b0, 1'b0);
    chk("midreset_after.fe", 32'(fe_count - fe0), 32'h0);
    send_frame(8'h81, 1'b1);
    check_out("post_reset_frame", 8'h81, 1'b1, 1'b0);

    // rx_ack landing exactly on the completion cycle of a good frame.
    // With a tick every clock the stop sample is 155 clocks after the start-bit edge:
    // 2 sync + 1 detect + 8 start + 8*16 data + 16 stop.
    do_reset;
    send_frame(8'h5A, 1'b1);
    check_out("same_cycle_first", 8'h5A, 1'b1, 1'b0);
    fork
      send_frame(8'hC3, 1'b1);
      begin
        @(posedge clk_in);
        repeat (154) @(posedge clk_in);
        #1 rx_ack = 1'b1;
        @(posedge clk_in);
        #1 rx_ack = 1'b0;
      end
    join
    check_out("same_cycle_ack", 8'hC3, 1'b1, 1'b0);

    // Tick every 3rd clock, back-to-back 0x00 then 0xFF, ack during the last stop bit.
    do_reset;
    tick_div = 3;
    send_frame(8'h00, 1'b1);
    check_out("slow_first", 8'h00, 1'b1, 1'b0);
    fork
      send_frame(8'hFF, 1'b1);
      begin
        @(posedge clk_in);
        wait_ticks(OS * (DB + 1) + 2);
        #1 rx_ack = 1'b1;
        @(posedge clk_in);
        #1 rx_ack = 1'b0;
      end
    join
    check_out("slow_second", 8'hFF, 1'b1, 1'b0);

    // Random frames against a frame-level reference model.
    do_reset;
    m_data  = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    for (int n = 0; n < 40; n++) begin
      logic [DB-1:0] d;
      logic          stop;
      logic          ack;
      int            gap;
      tick_div = $urandom_range(1, 3);
      d        = DB'($urandom);
      stop     = ($urandom_range(0, 4) != 0);
      ack      = 1'($urandom_range(0, 1));
      gap      = stop ? $urandom_range(0, 4) : 20;
      fe0      = fe_count;
      send_frame(d, stop);
      wait_ticks(gap);
      if (stop) begin
        if (m_valid) m_ovr = 1'b1;
        m_data  = d;
        m_valid = 1'b1;
      end
      check_out($sformatf("rand%0d", n), m_data, m_valid, m_ovr);
      chk($sformatf("rand%0d.fe", n), 32'(fe_count - fe0), stop ? 32'h0 : 32'h1);
      if (ack) begin
        pulse_ack;
        m_valid = 1'b0;
      end
    end
    #2;
    chk("rand_end.rx_valid", 32'(rx_valid), 32'(m_valid));

    chk("framing_err_single_cycle", 32'(fe_wide), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
